// File: rtl/seq_bit_serializer_if.sv
// Parallel-in / serial-out bus for seq_bit_serializer: word handshake plus serial stream.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, frame_start, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, frame_start, busy
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer feeding serial sequence detectors; optional gap between frames.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
module seq_bit_serializer #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_bit_serializer_if.slave  bus
);

`ifdef SER_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int            CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_BIT = CW'(FL - 1);
  localparam bit            HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [3:0]    GAP_LAST = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             sout_q, sout_d;
  logic             vld_q, vld_d;
  logic             fs_q, fs_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             accept, load, advance;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sr_d    = sr_q;
    sout_d  = 1'b0;
    vld_d   = 1'b0;
    fs_d    = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif
    accept  = bus.din_valid & rdy_q;

    case (state_q)
      IDLE: if (accept) load = 1'b1;
      SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          if (HAS_GAP) begin
            state_d = GAP;
            gap_d   = 4'd0;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          advance = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (accept) load = 1'b1;
          else        state_d = IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The accept edge already drives the first bit, so the word is stored pre-shifted.
    if (load) begin
      state_d = SHIFT;
      cnt_d   = '0;
      sr_d    = shift_out(bus.din);
      sout_d  = head_bit(bus.din);
      vld_d   = 1'b1;
      fs_d    = 1'b1;
`ifdef SER_PARITY_EN
      par_d   = ^bus.din;
`endif
    end

    if (advance) begin
      cnt_d  = cnt_q + 1'b1;
      sr_d   = shift_out(sr_q);
      sout_d = head_bit(sr_q);
      vld_d  = 1'b1;
`ifdef SER_PARITY_EN
      if (cnt_d == CW'(WIDTH)) sout_d = par_q;
`endif
    end

    // Ready is registered from the next state so the handshake never adds a bubble.
    rdy_d  = (state_d == IDLE) ||
             (state_d == SHIFT && !HAS_GAP && cnt_d == LAST_BIT) ||
             (state_d == GAP && gap_d == GAP_LAST);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      sr_q    <= '0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
      fs_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sr_q    <= sr_d;
      sout_q  <= sout_d;
      vld_q   <= vld_d;
      fs_q    <= fs_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.din_ready   = rdy_q;
  assign bus.sout        = sout_q;
  assign bus.sout_valid  = vld_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: a default instance and a gapped LSB-first instance, both tracked by a frame model.
module tb_seq_bit_serializer;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int FLEN = W + 1;
  localparam bit PAR  = 1'b1;
`else
  localparam int FLEN = W;
  localparam bit PAR  = 1'b0;
`endif

  typedef struct {
    logic [7:0] din;
    logic [7:0] msb_seq;
    logic [7:0] lsb_seq;
    logic       par;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] din_t [2];
  logic         vld_t [2] = '{1'b0, 1'b0};
  logic [4:0]   obs   [2];

  seq_bit_serializer_if #(.WIDTH(W)) if_a ();
  seq_bit_serializer_if #(.WIDTH(W)) if_b ();

  assign if_a.din       = din_t[0];
  assign if_a.din_valid = vld_t[0];
  assign if_b.din       = din_t[1];
  assign if_b.din_valid = vld_t[1];
  assign obs[0] = {if_a.din_ready, if_a.busy, if_a.frame_start, if_a.sout_valid, if_a.sout};
  assign obs[1] = {if_b.din_ready, if_b.busy, if_b.frame_start, if_b.sout_valid, if_b.sout};

  seq_bit_serializer #(.WIDTH(W), .GAP_CYCLES(0), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  seq_bit_serializer #(.WIDTH(W), .GAP_CYCLES(2), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic bit msb_of(input int d);
    return (d == 0);
  endfunction

  // Frame model: each accepted word occupies FLEN bit slots followed by gap slots.
  bit           m_up = 1'b0;
  bit           m_act [2] = '{1'b0, 1'b0};
  int           m_pos [2] = '{0, 0};
  logic [W-1:0] m_word [2];

  function automatic logic bit_at(input logic [W-1:0] w, input int pos, input bit msb);
    if (pos >= W) return ^w;
    return msb ? w[W-1-pos] : w[pos];
  endfunction

  function automatic bit m_rdy(input int d);
    return m_up && (!m_act[d] || m_pos[d] == FLEN + gap_of(d) - 1);
  endfunction

  function automatic logic [4:0] exp_obs(input int d);
    logic v, f, s;
    v = m_act[d] && (m_pos[d] < FLEN);
    f = v && (m_pos[d] == 0);
    s = v && bit_at(m_word[d], m_pos[d], msb_of(d));
    return {m_rdy(d), m_act[d], f, v, s};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_up <= 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_act[d] <= 1'b0;
        m_pos[d] <= 0;
      end
    end else begin
      m_up <= 1'b1;
      for (int d = 0; d < 2; d++) begin
        if (m_rdy(d) && vld_t[d]) begin
          m_act[d]  <= 1'b1;
          m_pos[d]  <= 0;
          m_word[d] <= din_t[d];
        end else if (m_act[d]) begin
          if (m_pos[d] == FLEN + gap_of(d) - 1) begin
            m_act[d] <= 1'b0;
            m_pos[d] <= 0;
          end else begin
            m_pos[d] <= m_pos[d] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++)
        check((d == 0) ? "stream_a" : "stream_b", 32'(obs[d]), 32'(exp_obs(d)));
    end
  end

  task automatic wait_fs(input int d, output bit found);
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      found = obs[d][2];
    end
    check("fs_seen", 32'(found), 32'd1);
  endtask

  task automatic frame1(input int d, input logic [W-1:0] w, output logic [8:0] seq);
    bit found;
    seq = '0;
    @(negedge clk);
    din_t[d] = w;
    vld_t[d] = 1'b1;
    wait_fs(d, found);
    vld_t[d] = 1'b0;
    if (found) begin
      for (int i = 0; i < FLEN; i++) begin
        if (i > 0) @(negedge clk);
        seq = {seq[7:0], obs[d][0]};
      end
    end
    repeat (gap_of(d) + 2) @(negedge clk);
  endtask

  // Two frames with valid held; din switches to wmid after the first accept and to w2 two cycles later.
  task automatic stream2(input int d, input logic [W-1:0] w1, input logic [W-1:0] wmid,
                         input logic [W-1:0] w2, input string tag);
    int n;
    int g;
    bit found;
    logic [31:0] sv, vv, rv, es, ev, er;
    g = gap_of(d);
    n = 2 * FLEN + g;
    sv = '0; vv = '0; rv = '0; es = '0; ev = '0; er = '0;
    @(negedge clk);
    din_t[d] = w1;
    vld_t[d] = 1'b1;
    wait_fs(d, found);
    if (found) begin
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        sv[i] = obs[d][0];
        vv[i] = obs[d][1];
        rv[i] = obs[d][4];
        if (i == 0) din_t[d] = wmid;
        if (i == 2) din_t[d] = w2;
        if (i == FLEN + g) vld_t[d] = 1'b0;
      end
    end
    vld_t[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i < FLEN) begin
        es[i] = bit_at(w1, i, msb_of(d));
        ev[i] = 1'b1;
      end else if (i >= FLEN + g) begin
        es[i] = bit_at(w2, i - FLEN - g, msb_of(d));
        ev[i] = 1'b1;
      end
      er[i] = (i == FLEN - 1 + g) || (g == 0 && i == n - 1);
    end
    check({tag, "_bits"}, sv, es);
    check({tag, "_valid"}, vv, ev);
    check({tag, "_ready"}, rv, er);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vec_t tbl [5];
    logic [8:0] seq;
    logic [8:0] exp9;
    logic [7:0] exp8;
    logic [7:0] seq8;
    logic [4:0] any_vld;
    bit found;
    int hits;

    tbl[0] = '{8'hB4, 8'b10110100, 8'b00101101, 1'b0};
    tbl[1] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1};
    tbl[2] = '{8'h55, 8'b01010101, 8'b10101010, 1'b0};
    tbl[3] = '{8'h01, 8'b00000001, 8'b10000000, 1'b1};
    tbl[4] = '{8'hA3, 8'b10100011, 8'b11000101, 1'b0};
    din_t[0] = '0;
    din_t[1] = '0;

    #1 reset = 1'b0;
    chk_en = 1'b1;
    #21 reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(obs[0]), 32'b10000);

    for (int i = 0; i < 5; i++) begin
      for (int d = 0; d < 2; d++) begin
        frame1(d, tbl[i].din, seq);
        exp8 = (d == 0) ? tbl[i].msb_seq : tbl[i].lsb_seq;
        exp9 = PAR ? {exp8, tbl[i].par} : {1'b0, exp8};
        check($sformatf("tbl_%0d_%0d", i, d), 32'(seq), 32'(exp9));
        if (i == 0 && d == 0) begin
          seq8 = PAR ? seq[8:1] : seq[7:0];
          hits = 0;
          for (int k = 0; k < 5; k++)
            if (seq8[7-k -: 4] == 4'b1011) hits++;
          check("det_1011_hits", 32'(hits), 32'd1);
        end
      end
    end

    stream2(0, 8'hB0, 8'h0B, 8'h0B, "b2b_a");
    stream2(1, 8'hB4, 8'h07, 8'h07, "gap_b");
    stream2(0, 8'hB4, 8'hFF, 8'h55, "bp_a");
    stream2(1, 8'h3C, 8'hFF, 8'hC5, "bp_b");

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    din_t[0] = 8'hB4;
    vld_t[0] = 1'b1;
    wait_fs(0, found);
    vld_t[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_async_a", 32'(obs[0]), 32'd0);
    check("rst_async_b", 32'(obs[1]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("rst_release_a", 32'(obs[0]), 32'b10000);
    any_vld = '0;
    repeat (FLEN + 2) begin
      @(negedge clk);
      any_vld = any_vld | obs[0];
    end
    check("no_remnant", 32'(any_vld[1:0]), 32'd0);

    foreach (tbl[i]) begin
      for (int d = 0; d < 2; d++) begin
        repeat (i + 1) @(negedge clk);
        vld_t[d] = 1'b0;
      end
    end

    for (int ph = 0; ph < 3; ph++) begin
      int p;
      p = (ph == 0) ? 90 : (ph == 1) ? 50 : 15;
      repeat (500) begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          vld_t[d] = ($urandom_range(0, 99) < 32'(p));
          din_t[d] = 8'($urandom);
        end
      end
    end
    vld_t[0] = 1'b0;
    vld_t[1] = 1'b0;
    repeat (30) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
